// File: rtl/booth_issue_ctrl_pkg.sv
// Shared state encoding and default sizing for the Booth operand issue controller.
package booth_issue_ctrl_pkg;

    localparam int DEF_W       = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/booth_issue_ctrl_sync_fifo.sv
// Small synchronous FIFO with a count register; full/empty are decoded from the count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/booth_issue_ctrl.sv
// Queues signed operand pairs, issues them one at a time to the Booth multiplier
// and returns each product on a ready/valid port.
module booth_issue_ctrl
    import booth_issue_ctrl_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_x,
    input  logic [W-1:0]             in_y,
    output logic                     mul_start,
    output logic [W-1:0]             mul_x,
    output logic [W-1:0]             mul_y,
    input  logic                     mul_valid,
    input  logic [prod_width(W)-1:0] mul_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_width(W)-1:0] out_z,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PW = prod_width(W);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [W-1:0]    mul_x_q, mul_x_d;
    logic [W-1:0]    mul_y_q, mul_y_d;
    logic [PW-1:0]   out_z_q, out_z_d;
    logic            out_valid_q, out_valid_d;
    logic            terr_q, terr_d;
    logic            valid_q;
    logic            valid_rise;

    logic            fifo_pop;
    logic [2*W-1:0]  fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    sync_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (in_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({in_x, in_y}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // mul_valid is a level; only its rising edge marks a fresh product.
    assign valid_rise = mul_valid && !valid_q;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        out_z_d     = out_z_q;
        out_valid_d = out_valid_q;
        terr_d      = terr_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop           = 1'b1;
                    {mul_x_d, mul_y_d} = fifo_rdata;
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A product arriving in the last allowed cycle still counts.
                if (valid_rise) begin
                    out_z_d     = mul_z;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (tcnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop           = 1'b1;
                        {mul_x_d, mul_y_d} = fifo_rdata;
                        state_d            = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            out_z_q     <= '0;
            out_valid_q <= 1'b0;
            terr_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            out_z_q     <= out_z_d;
            out_valid_q <= out_valid_d;
            terr_q      <= terr_d;
            valid_q     <= mul_valid;
        end
    end

    assign in_ready    = !fifo_full;
    assign mul_start   = (state_q == ST_ISSUE);
    assign mul_x       = mul_x_q;
    assign mul_y       = mul_y_q;
    assign out_valid   = out_valid_q;
    assign out_z       = out_z_q;
    assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a behavioural multiplier and a product scoreboard.
module tb_booth_issue_ctrl;

    localparam int W       = 4;
    localparam int PW      = 2 * W;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 2;
    localparam logic [20:0] RESET_VEC = 21'h1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic          mul_start;
    logic [W-1:0]  mul_x;
    logic [W-1:0]  mul_y;
    logic          mul_valid;
    logic [PW-1:0] mul_z;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_z;
    logic          busy;
    logic          timeout_err;

    logic          stall = 1'b0;
    logic          dead = 1'b0;
    logic          running;
    int            lcnt;

    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] sb [$];

    booth_issue_ctrl #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .mul_start   (mul_start),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_valid   (mul_valid),
        .mul_z       (mul_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mulRef(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = a;
        eb = b;
        return PW'(ea * eb);
    endfunction

    function automatic logic [20:0] outVec();
        return {mul_start, mul_x, mul_y, out_valid, out_z, busy, timeout_err, in_ready};
    endfunction

    // Multiplier model: start drops valid, then after LAT+1 unstalled cycles the
    // product of the operands present at that time is raised and held.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_valid <= 1'b0;
            mul_z     <= '0;
            running   <= 1'b0;
            lcnt      <= 0;
        end else if (mul_start) begin
            mul_valid <= 1'b0;
            running   <= 1'b1;
            lcnt      <= LAT;
        end else if (running && !stall && !dead) begin
            if (lcnt == 0) begin
                mul_valid <= 1'b1;
                mul_z     <= mulRef(mul_x, mul_y);
                running   <= 1'b0;
            end else begin
                lcnt <= lcnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one pair and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                 input logic logExp);
        int n;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        if (logExp) sb.push_back(mulRef(x, y));
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("push_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic popResult(input string tag, input int hold, input logic expIssue);
        int n;
        logic [PW-1:0] exp;
        logic [PW-1:0] held;
        logic stableOk;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_seen"}, out_valid, 1'b1);
        checkOutput({tag, "_sbq"}, sb.size() != 0, 1'b1);
        if (out_valid === 1'b1 && sb.size() != 0) begin
            exp = sb.pop_front();
            checkOutput({tag, "_z"}, out_z, exp);
            held = out_z;
            stableOk = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || out_z !== held) stableOk = 1'b0;
            end
            if (hold > 0) checkOutput({tag, "_hold"}, stableOk, 1'b1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checkOutput({tag, "_drop"}, out_valid, 1'b0);
            checkOutput({tag, "_issue"}, mul_start, expIssue);
        end
    endtask

    initial begin
        int n;
        logic flag;
        logic signed [W-1:0] t4x [5];
        logic signed [W-1:0] t4y [5];
        t4x = '{4'sd1, -4'sd2, 4'sd3, -4'sd5, 4'sd7};
        t4y = '{4'sd7, 4'sd3, -4'sd6, -4'sd5, 4'sd2};

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t1_in_reset", outVec(), RESET_VEC);
        rst = 1'b1;
        flag = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (mul_start !== 1'b0 || busy !== 1'b0) flag = 1'b0;
        end
        checkOutput("t1_quiet", flag, 1'b1);
        checkOutput("t1_after", outVec(), RESET_VEC);

        $display("[TB] single op 5*7");
        applyStimulus(4'sd5, 4'sd7, 1'b1);
        checkOutput("t2_start_t1", mul_start, 1'b0);
        checkOutput("t2_busy", busy, 1'b1);
        @(posedge clk); #1;
        checkOutput("t2_start_t2", mul_start, 1'b1);
        checkOutput("t2_mul_x", mul_x, 4'd5);
        checkOutput("t2_mul_y", mul_y, 4'd7);
        @(posedge clk); #1;
        checkOutput("t2_start_once", mul_start, 1'b0);
        flag = 1'b1;
        n = 0;
        while (mul_valid !== 1'b1 && n < 30) begin
            if (mul_x !== 4'd5 || mul_y !== 4'd7) flag = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t2_mv_seen", mul_valid, 1'b1);
        checkOutput("t2_xy_stable", flag, 1'b1);
        checkOutput("t2_ov_pre", out_valid, 1'b0);
        @(posedge clk); #1;
        checkOutput("t2_ov_rise", out_valid, 1'b1);
        checkOutput("t2_z_const", out_z, 8'd35);
        popResult("t2", 0, 1'b0);

        $display("[TB] back-to-back with held result");
        applyStimulus(-4'sd4, 4'sd6, 1'b1);
        applyStimulus(-4'sd8, -4'sd8, 1'b1);
        popResult("t3_a", 10, 1'b1);
        popResult("t3_b", 0, 1'b0);

        $display("[TB] fill fifo with stalled multiplier");
        stall = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(t4x[i], t4y[i], 1'b1);
        checkOutput("t4_full", in_ready, 1'b0);
        in_valid = 1'b1;
        in_x = 4'sd6;
        in_y = -4'sd3;
        sb.push_back(mulRef(4'sd6, -4'sd3));
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("t4_held", in_ready, 1'b0);
        stall = 1'b0;
        popResult("t4_r0", 0, 1'b1);
        checkOutput("t4_space", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 6; i++) popResult($sformatf("t4_r%0d", i), 0, i < 5);

        $display("[TB] multiplier timeout");
        dead = 1'b1;
        applyStimulus(4'sd6, 4'sd3, 1'b0);
        n = 0;
        while (mul_start !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t5_issue", mul_start, 1'b1);
        flag = 1'b1;
        repeat (TIMEOUT) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) flag = 1'b0;
        end
        checkOutput("t5_err_early", timeout_err, 1'b0);
        @(posedge clk); #1;
        checkOutput("t5_err_set", timeout_err, 1'b1);
        checkOutput("t5_idle", busy, 1'b0);
        checkOutput("t5_no_out", flag, 1'b1);
        dead = 1'b0;
        applyStimulus(4'sd3, -4'sd2, 1'b1);
        popResult("t5_next", 0, 1'b0);
        checkOutput("t5_sticky", timeout_err, 1'b1);

        $display("[TB] reset during wait");
        stall = 1'b1;
        applyStimulus(4'sd7, 4'sd7, 1'b0);
        applyStimulus(4'sd2, 4'sd2, 1'b0);
        applyStimulus(4'sd3, 4'sd3, 1'b0);
        @(posedge clk); #1;
        checkOutput("t6_busy", busy, 1'b1);
        checkOutput("t6_mul_x", mul_x, 4'd7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async", outVec(), RESET_VEC);
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        flag = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (mul_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) flag = 1'b0;
        end
        checkOutput("t6_quiet", flag, 1'b1);
        applyStimulus(-4'sd8, 4'sd7, 1'b1);
        popResult("t6_new", 0, 1'b0);
        checkOutput("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
